hx8352_cmd_queue: RTL and testbench

- Command queue between the Nios PIO LCD-control word and hx8352_controller.
- Captures {cmd[3:0], data[15:0]} each time software toggles the step bit, and buffers entries in a FIFO.
- Replays entries to the controller one at a time using the step/busy handshake, so software can issue bursts without polling busy.
- Exposes level and status flags for PIO readback.

---
 rtl/hx8352_pkg.sv | 22 ++
 rtl/hx8352_cmd_queue_sync_fifo.sv | 75 +++++++
 rtl/hx8352_cmd_queue.sv | 125 ++++++++++++
 tb/tb_hx8352_cmd_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hx8352_pkg.sv
// Shared types and defaults for the HX8352 LCD command queue.
package hx8352_pkg;

    localparam int CMD_W           = 4;
    localparam int DATA_W          = 16;
    localparam int ENTRY_W         = CMD_W + DATA_W;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_ACK_TIMEOUT = 8;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } drain_state_e;

endpackage

// File: rtl/hx8352_cmd_queue_sync_fifo.sv
// Single-clock FIFO with flush. Level comes from a counter so full/empty never
// depend on pointer arithmetic; overflow policy is left to the instantiating block.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/hx8352_cmd_queue.sv
// Buffers PIO-written LCD commands and replays them to hx8352_controller one at a time.
// Handshake: lcd_step pulses one cycle; the controller may raise lcd_busy, and the entry is done when busy falls or never rises within ACK_TIMEOUT cycles.
module hx8352_cmd_queue
    import hx8352_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_toggle,
    input  logic [CMD_W-1:0]        wr_cmd,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    flush,
    input  logic                    lcd_init_done,
    input  logic                    lcd_busy,
    output logic                    lcd_step,
    output logic [CMD_W-1:0]        lcd_cmd,
    output logic [DATA_W-1:0]       lcd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    idle,
    output drain_state_e            state_dbg
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    drain_state_e   state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           wr_prev_q;
    logic           overflow_q, overflow_d;
    entry_t         lcd_q;
    entry_t         wr_entry;
    entry_t         head;
    logic           push_req;
    logic           pop;

    assign wr_entry = '{cmd: wr_cmd, data: wr_data};
    assign push_req = (wr_toggle != wr_prev_q);
    assign pop      = (state_q == ST_IDLE) && !empty && lcd_init_done && !lcd_busy && !flush;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push_req),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pop) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (lcd_busy)                              state_d = ST_WAIT_DONE;
                else if (timer_q == TW'(ACK_TIMEOUT - 1))  state_d = ST_IDLE;
            end
            ST_WAIT_DONE: if (!lcd_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lcd_step  = (state_q == ST_ISSUE);
        idle      = empty && (state_q == ST_IDLE);
        state_dbg = state_q;
    end

    always_comb begin
        timer_d = timer_q;
        if (state_q == ST_ISSUE) begin
            timer_d = '0;
        end else if (state_q == ST_WAIT_ACK && !lcd_busy) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // A full-queue write is only lost when nothing drains in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_prev_q  <= wr_toggle;
            overflow_q <= 1'b0;
            timer_q    <= '0;
            lcd_q      <= '0;
        end else begin
            wr_prev_q  <= wr_toggle;
            overflow_q <= overflow_d;
            timer_q    <= timer_d;
            if (pop) lcd_q <= head;
        end
    end

    assign overflow = overflow_q;
    assign lcd_cmd  = lcd_q.cmd;
    assign lcd_data = lcd_q.data;

endmodule

// File: tb/tb_hx8352_cmd_queue.sv
// Directed bench for hx8352_cmd_queue: write capture, full/overflow, drain order,
// handshake timing, flush and reset behaviour against a simple controller busy model.
module tb_hx8352_cmd_queue;
    import hx8352_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_toggle;
    logic [3:0]          wr_cmd;
    logic [15:0]         wr_data;
    logic                flush;
    logic                lcd_init_done;
    logic                lcd_busy;
    logic                lcd_step;
    logic [3:0]          lcd_cmd;
    logic [15:0]         lcd_data;
    logic [4:0]          level;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                idle;
    drain_state_e        state_dbg;

    int                  errors = 0;
    int                  checks = 0;
    int                  cyc = 0;
    int                  step_count = 0;
    int                  busy_len = 5;
    int                  busy_cnt = 0;
    int                  step_cyc[$];
    logic [19:0]         exp_q[$];

    hx8352_cmd_queue #(.DEPTH(16), .ACK_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_toggle     (wr_toggle),
        .wr_cmd        (wr_cmd),
        .wr_data       (wr_data),
        .flush         (flush),
        .lcd_init_done (lcd_init_done),
        .lcd_busy      (lcd_busy),
        .lcd_step      (lcd_step),
        .lcd_cmd       (lcd_cmd),
        .lcd_data      (lcd_data),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .idle          (idle),
        .state_dbg     (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Controller model: busy rises the cycle after a step and stays up busy_len cycles.
    always @(posedge clk) begin
        if (lcd_step && busy_len > 0) begin
            lcd_busy <= 1'b1;
            busy_cnt <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            lcd_busy <= 1'b0;
        end
    end

    // scoreboard: every issued step must carry the next expected entry
    always @(negedge clk) begin
        if (lcd_step) begin
            step_count++;
            step_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'({lcd_cmd, lcd_data}), 32'hFFFFFFFF);
            end else begin
                check("step_entry", 32'({lcd_cmd, lcd_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] c, input logic [15:0] d);
        wr_cmd    = c;
        wr_data   = d;
        wr_toggle = ~wr_toggle;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (!(idle && !lcd_busy) && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic wait_state(input string tag, input drain_state_e s, input int max);
        int n = 0;
        while (state_dbg != s && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        int base;
        rst_n         = 1'b0;
        wr_toggle     = 1'b1;
        wr_cmd        = 4'h0;
        wr_data       = 16'h0;
        flush         = 1'b0;
        lcd_init_done = 1'b0;
        lcd_busy      = 1'b0;

        // 1: reset with wr_toggle held high, no spurious write
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_lcd_cmd", 32'(lcd_cmd), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_no_step", 32'(step_count), 32'd0);

        // 2: single write, step two cycles after the toggle cycle
        lcd_init_done = 1'b1;
        busy_len      = 5;
        exp_q.push_back({4'h2, 16'hF800});
        do_write(4'h2, 16'hF800);
        check("single_level_n1", 32'(level), 32'd1);
        check("single_no_early_step", 32'(lcd_step), 32'd0);
        tick();
        check("single_step_n2", 32'(lcd_step), 32'd1);
        check("single_cmd", 32'(lcd_cmd), 32'h2);
        check("single_data", 32'(lcd_data), 32'hF800);
        tick();
        check("single_step_one_cycle", 32'(lcd_step), 32'd0);
        wait_idle("single_idle", 30);
        check("single_count", 32'(step_count), 32'd1);

        // 3: overfill with init_done low, then drain in order
        lcd_init_done = 1'b0;
        busy_len      = 1;
        for (int i = 0; i < 20; i++) do_write(4'h1, 16'(i));
        check("fill_level", 32'(level), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_no_step", 32'(step_count), 32'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back({4'h1, 16'(i)});
        step_cyc.delete();
        base = step_count;
        lcd_init_done = 1'b1;
        wait_idle("drain_idle", 200);
        check("drain_count", 32'(step_count - base), 32'd16);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 1; i < step_cyc.size(); i++) begin
            check("drain_spacing", 32'(step_cyc[i] - step_cyc[i-1]), 32'd4);
        end

        // 4: push while full in the same cycle as a pop
        do_flush();
        check("flush_overflow_clr", 32'(overflow), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        lcd_init_done = 1'b0;
        for (int i = 0; i < 16; i++) do_write(4'h3, 16'(16'h100 + i));
        for (int i = 0; i < 16; i++) exp_q.push_back({4'h3, 16'(16'h100 + i)});
        exp_q.push_back({4'h3, 16'h01FF});
        check("pp_full_before", 32'(full), 32'd1);
        base = step_count;
        lcd_init_done = 1'b1;
        do_write(4'h3, 16'h01FF);
        check("pp_level", 32'(level), 32'd16);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_step", 32'(lcd_step), 32'd1);
        wait_idle("pp_idle", 200);
        check("pp_count", 32'(step_count - base), 32'd17);
        check("pp_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: controller never raises busy, steps separated by the ack timeout
        busy_len      = 0;
        lcd_init_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_write(4'h4, 16'(16'h200 + i));
            exp_q.push_back({4'h4, 16'(16'h200 + i)});
        end
        step_cyc.delete();
        lcd_init_done = 1'b1;
        wait_idle("to_idle", 100);
        check("to_count", 32'(step_cyc.size()), 32'd3);
        for (int i = 1; i < step_cyc.size(); i++) begin
            check("to_spacing", 32'(step_cyc[i] - step_cyc[i-1]), 32'd10);
        end

        // 6a: flush during WAIT_DONE of the first of five entries
        busy_len      = 5;
        lcd_init_done = 1'b0;
        for (int i = 0; i < 5; i++) do_write(4'h5, 16'(16'hA0 + i));
        exp_q.push_back({4'h5, 16'h00A0});
        base = step_count;
        lcd_init_done = 1'b1;
        wait_state("fl_reach_wait_done", ST_WAIT_DONE, 20);
        do_flush();
        check("fl_level", 32'(level), 32'd0);
        check("fl_overflow", 32'(overflow), 32'd0);
        check("fl_inflight", 32'(state_dbg), 32'(ST_WAIT_DONE));
        check("fl_data_hold", 32'(lcd_data), 32'hA0);
        wait_idle("fl_idle", 30);
        repeat (20) tick();
        check("fl_count", 32'(step_count - base), 32'd1);
        check("fl_data_after", 32'(lcd_data), 32'hA0);

        // 6b: reset during WAIT_ACK abandons the handshake
        exp_q.push_back({4'h6, 16'hBEEF});
        base = step_count;
        do_write(4'h6, 16'hBEEF);
        wait_state("rs_reach_wait_ack", ST_WAIT_ACK, 10);
        rst_n = 1'b0;
        tick();
        check("rs_step", 32'(lcd_step), 32'd0);
        check("rs_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rs_data", 32'(lcd_data), 32'd0);
        check("rs_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("rs_count", 32'(step_count - base), 32'd1);
        check("rs_idle", 32'(idle), 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
